// File: rtl/filter_sched.sv
// rtl/filter_sched.sv - round-robin scheduler sharing one filter cascade among four channels
module filter_sched #(
  parameter int NCH     = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    req,
  input  logic [32*NCH-1:0] din,
  input  logic [4*NCH-1:0]  a1_ch,
  input  logic [4*NCH-1:0]  a2_ch,
  output logic [NCH-1:0]    ack,
  output logic              f_once,
  output logic [31:0]       f_in,
  output logic [3:0]        f_a1,
  output logic [3:0]        f_a2,
  input  logic              f_done,
  input  logic [31:0]       f_out,
  output logic [31:0]       res,
  output logic [1:0]        res_ch,
  output logic              res_valid,
  output logic              busy,
  output logic              err,
  input  logic              clr_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} state_t;

  state_t        state, state_nx;
  logic [1:0]    last, cur, gnt;
  logic          gnt_valid;
  logic [CW-1:0] cnt;
  logic          timeout;

  // Round-robin pick: search starts just after the last served channel and wraps.
  always_comb begin
    gnt       = last;
    gnt_valid = 1'b0;
    for (int i = 1; i <= NCH; i++) begin
      if (!gnt_valid && req[2'(last + 2'(i))]) begin
        gnt_valid = 1'b1;
        gnt       = 2'(last + 2'(i));
      end
    end
  end

  // Abort condition: waited the full budget and the filter still has not answered.
  assign timeout = (state == WAIT) && !f_done && (cnt == CW'(TIMEOUT));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic and the per-state pulse outputs.
  always_comb begin
    state_nx  = state;
    f_once    = 1'b0;
    res_valid = 1'b0;
    ack       = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (gnt_valid) state_nx = ISSUE;
      ISSUE: begin
        f_once   = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        if (f_done) begin
          state_nx = STORE;
        end else if (timeout) begin
          ack      = NCH'(1) << cur;
          state_nx = IDLE;
        end
      end
      STORE: begin
        res_valid = 1'b1;
        ack       = NCH'(1) << cur;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Job datapath: grant latch, wait counter, result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last   <= 2'd3;
      cur    <= 2'd0;
      f_in   <= '0;
      f_a1   <= '0;
      f_a2   <= '0;
      cnt    <= '0;
      res    <= '0;
      res_ch <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            cur  <= gnt;
            last <= gnt;
            f_in <= din[{gnt, 5'b0} +: 32];
            f_a1 <= a1_ch[{gnt, 2'b0} +: 4];
            f_a2 <= a2_ch[{gnt, 2'b0} +: 4];
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (f_done) begin
            res    <= f_out;
            res_ch <= cur;
          end else if (!timeout) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky error flag; a timeout outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err <= 1'b0;
    else if (timeout) err <= 1'b1;
    else if (clr_err) err <= 1'b0;
  end

endmodule

// File: doc/filter_sched.md
FILTER_SCHED -- requirements
Module: filter_sched

Interface
REQ-001 Parameter NCH, default 4: number of requesting channels, fixed at 4 for this revision.
REQ-002 Parameter TIMEOUT, default 255: maximum cycles WAIT may last before abort.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  4  per-channel level request; held high until matching ack.
REQ-006 din  input  128  channel samples; channel c is din[32c+31:32c].
REQ-007 a1_ch  input  16  stage-1 coefficient codes; channel c is a1_ch[4c+3:4c].
REQ-008 a2_ch  input  16  stage-2 coefficient codes; channel c is a2_ch[4c+3:4c].
REQ-009 ack  output  4  one-cycle pulse to the served channel at job end.
REQ-010 f_once  output  1  one-cycle start pulse to the shared filter cascade.
REQ-011 f_in  output  32  sample presented to the filter.
REQ-012 f_a1 / f_a2  output  4 each  coefficient codes presented to the filter.
REQ-013 f_done  input  1  completion pulse from the filter.
REQ-014 f_out  input  32  filter result; valid in the f_done cycle.
REQ-015 res  output  32  last result.
REQ-016 res_ch  output  2  channel index of res.
REQ-017 res_valid  output  1  one-cycle pulse when res/res_ch update.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 err  output  1  sticky timeout flag.
REQ-020 clr_err  input  1  synchronous clear of err.

Function
REQ-021 FSM states: IDLE, ISSUE, WAIT, STORE; the FSM has no other states.
REQ-022 IDLE: if any req bit is high, grant by round robin starting at (last+1) mod 4, then go to ISSUE; otherwise stay in IDLE.
REQ-023 On grant, the block latches the granted channel's din, a1, a2 and index into f_in, f_a1, f_a2 and a current-channel register, and updates last.
REQ-024 f_in, f_a1 and f_a2 hold their values from grant until the next grant.
REQ-025 ISSUE: drive f_once=1 for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-026 WAIT: f_done=1 captures f_out into res and goes to STORE; otherwise the counter increments.
REQ-027 WAIT timeout: when the counter equals TIMEOUT with f_done=0, set err, pulse ack for the current channel with res_valid=0, and go to IDLE.
REQ-028 If f_done and the timeout condition occur in the same cycle, f_done wins.
REQ-029 STORE: drive res_valid=1, drive ack[current]=1, and update res_ch, all in one cycle; then go to IDLE.
REQ-030 Request-to-grant latency is 1 cycle; grant-to-f_once is 1 cycle; f_done-to-res_valid is 1 cycle; minimum turnaround per job is 4 cycles plus filter latency.
REQ-031 f_done outside WAIT is ignored and changes no outputs.
REQ-032 A req bit dropped before its grant is not served.
REQ-033 req is sampled only in IDLE.
REQ-034 The round-robin pointer wraps from 3 to 0.
REQ-035 A channel that keeps req high after ack is eligible again only after all other pending channels are served.
REQ-036 clr_err=1 clears err in the next cycle; if clr_err=1 and a timeout occur in the same cycle, err is set.
REQ-037 ack has at most one bit high at a time.
REQ-038 f_once never asserts while busy is high outside ISSUE.

Reset
REQ-039 While rst=0, regardless of clk: state=IDLE, last=3 (so channel 0 has first priority), counter=0, and res, res_ch, f_in, f_a1 and f_a2 are 0.
REQ-040 While rst=0: f_once, ack, res_valid, busy and err are all 0.
REQ-041 Reset asserted mid-job aborts the job with no ack, and the filter's pending f_done after release is ignored per REQ-031.
REQ-042 The first grant occurs no earlier than the first rising edge after rst returns high.

Verification
REQ-043 Single request: req=0001, din[31:0]=0x00001000, filter model returning f_done 3 cycles after f_once with f_out=0x00000800 -> f_once 2 cycles after req, f_in=0x1000, res=0x800, res_ch=0, res_valid and ack[0] together one cycle after f_done.
REQ-044 All four channels high from reset, held until ack -> service order 0,1,2,3, each with exactly one ack, and no f_once overlap.
REQ-045 Channel 2 keeps req high while channel 0 rerequests -> order alternates 2,0,2,0.
REQ-046 Filter model never raises f_done, TIMEOUT=255 -> ack pulse 256 cycles after entering WAIT, res_valid stays 0, err=1; clr_err=1 then gives err=0.
REQ-047 rst pulled low during WAIT with a late f_done arriving after release -> no res_valid and no ack, busy=0, and the next req is served normally.
REQ-048 f_done on the exact timeout cycle -> result stored, res_valid=1, err stays 0.
